coax_link_ctrl: RTL and testbench

//  Half-duplex transaction sequencer for the 3270 coax line. Streams a host command
//  (10-bit words) into coax_tx, then gates coax_rx on and waits for the response.

---
 rtl/coax_link_ctrl_pkg.sv | 37 +++
 rtl/coax_link_timer.sv | 37 +++
 rtl/coax_link_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_coax_link_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coax_link_ctrl_pkg.sv
// Shared definitions for the coax link controller: word widths, status codes,
// sequencer state encoding and the coax_rx error codes.
package coax_link_ctrl_pkg;

    localparam int unsigned WORD_W  = 10;
    localparam int unsigned STATS_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        STATUS_OK       = 2'b00,
        STATUS_TIMEOUT  = 2'b01,
        STATUS_RX_ERROR = 2'b10
    } status_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX       = 3'd1,
        ST_TX_DRAIN = 3'd2,
        ST_RX_WAIT  = 3'd3,
        ST_RX       = 3'd4,
        ST_RECOVER  = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    // Error codes reported by coax_rx on crx_data while crx_error is high
    localparam word_t LOSS_OF_MID_BIT_TRANSITION_ERROR = 10'b00_0000_0001;
    localparam word_t PARITY_ERROR                     = 10'b00_0000_0010;
    localparam word_t INVALID_END_SEQUENCE_ERROR       = 10'b00_0000_0100;
    localparam word_t OVERFLOW_ERROR                   = 10'b00_0000_1000;

    // Saturating increment for the statistics counters
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/coax_link_timer.sv
// Clear/enable up-counter with a terminal-count flag.
// Ports: clk, reset_n (sync, active-low), clear (restart at 0), enable (count),
//        limit (terminal value), tc_c (count == limit, combinational).
module coax_link_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             tc_c
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_c = (count_q == limit);

endmodule

// File: rtl/coax_link_ctrl.sv
// Half-duplex transaction sequencer between the host and the coax_tx/coax_rx pair.
// Streams a host command into coax_tx, enables coax_rx, forwards response words
// through a one-word buffer and reports OK / TIMEOUT / RX_ERROR with a done pulse.
// Host side : tx_valid/tx_word/tx_last/tx_ready, rsp_valid/rsp_word/rsp_ready,
//             busy, done, status, err_code.
// coax_tx   : ctx_data, ctx_load, ctx_ready, ctx_active.
// coax_rx   : crx_data, crx_data_available, crx_error, crx_active,
//             crx_read, crx_reset, crx_enable.
// Optional  : COAX_LINK_CTRL_STATS_EN adds timeout_count / error_count outputs.
module coax_link_ctrl
    import coax_link_ctrl_pkg::*;
#(
    parameter int unsigned RESPONSE_TIMEOUT = 512,
    parameter int unsigned RECOVER_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tx_valid,
    input  logic [WORD_W-1:0] tx_word,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_word,
    input  logic              rsp_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [WORD_W-1:0] err_code,
    output logic [WORD_W-1:0] ctx_data,
    output logic              ctx_load,
    input  logic              ctx_ready,
    input  logic              ctx_active,
    input  logic [WORD_W-1:0] crx_data,
    input  logic              crx_data_available,
    input  logic              crx_error,
    input  logic              crx_active,
    output logic              crx_read,
    output logic              crx_reset,
    output logic              crx_enable
`ifdef COAX_LINK_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0] timeout_count,
    output logic [STATS_W-1:0] error_count
`endif
);

    localparam int unsigned MAX_CNT = (RESPONSE_TIMEOUT > RECOVER_CYCLES) ? RESPONSE_TIMEOUT
                                                                          : RECOVER_CYCLES;
    localparam int unsigned TW = $clog2(MAX_CNT + 1);

    state_e  state_q, state_d;
    word_t   ctx_data_q, ctx_data_d;
    logic    ctx_load_q, ctx_load_d;
    logic    seen_active_q, seen_active_d;
    logic    rsp_valid_q, rsp_valid_d;
    word_t   rsp_word_q, rsp_word_d;
    logic    crx_read_q, crx_read_d;
    word_t   err_hold_q, err_hold_d;
    logic    done_q, done_d;
    status_e status_q, status_d;
    word_t   err_code_q, err_code_d;
    logic    busy_q, busy_d;
    logic    crx_enable_q, crx_enable_d;
    logic    crx_reset_q, crx_reset_d;
`ifdef COAX_LINK_CTRL_STATS_EN
    logic [STATS_W-1:0] timeout_count_q, timeout_count_d;
    logic [STATS_W-1:0] error_count_q, error_count_d;
`endif

    logic          tx_ready_c;
    logic          tx_hs;
    logic          rx_phase;
    logic          timer_tc;
    logic [TW-1:0] timer_limit;

    // Ready is a decode of registered state; held low while in reset
    assign tx_ready_c = reset_n && ((state_q == ST_IDLE) || (state_q == ST_TX))
                        && ctx_ready && !ctx_load_q;
    assign tx_hs      = tx_valid && tx_ready_c;
    assign rx_phase   = (state_q == ST_RX_WAIT) || (state_q == ST_RX);

    // One shared timer: response timeout in RX_WAIT, reset hold in RECOVER
    assign timer_limit = (state_q == ST_RECOVER) ? TW'(RECOVER_CYCLES - 1)
                                                 : TW'(RESPONSE_TIMEOUT - 1);

    coax_link_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_d != state_q),
        .enable  ((state_q == ST_RX_WAIT) || (state_q == ST_RECOVER)),
        .limit   (timer_limit),
        .tc_c    (timer_tc)
    );

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        ctx_data_d    = ctx_data_q;
        ctx_load_d    = 1'b0;
        seen_active_d = seen_active_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_word_d    = rsp_word_q;
        crx_read_d    = 1'b0;
        err_hold_d    = err_hold_q;
        done_d        = 1'b0;
        status_d      = status_q;
        err_code_d    = err_code_q;

        if (tx_hs) begin
            ctx_data_d = tx_word;
            ctx_load_d = 1'b1;
        end

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        // crx_read_q guard: coax_rx still shows the word in the cycle of the strobe
        if (rx_phase && !crx_error && crx_data_available && !rsp_valid_q && !crx_read_q) begin
            crx_read_d  = 1'b1;
            rsp_word_d  = crx_data;
            rsp_valid_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                seen_active_d = 1'b0;
                if (tx_hs) begin
                    state_d = tx_last ? ST_TX_DRAIN : ST_TX;
                end
            end
            ST_TX: begin
                if (ctx_active) begin
                    seen_active_d = 1'b1;
                end
                if (tx_hs && tx_last) begin
                    state_d = ST_TX_DRAIN;
                end
            end
            ST_TX_DRAIN: begin
                if (ctx_active) begin
                    seen_active_d = 1'b1;
                end else if (seen_active_q && !ctx_load_q) begin
                    state_d = ST_RX_WAIT;
                end
            end
            ST_RX_WAIT: begin
                if (crx_error) begin
                    err_hold_d  = crx_data;
                    rsp_valid_d = 1'b0;
                    state_d     = ST_RECOVER;
                end else if (crx_active) begin
                    state_d = ST_RX;
                end else if (timer_tc) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    status_d   = STATUS_TIMEOUT;
                    err_code_d = '0;
                end
            end
            ST_RX: begin
                if (crx_error) begin
                    err_hold_d  = crx_data;
                    rsp_valid_d = 1'b0;
                    state_d     = ST_RECOVER;
                end else if (!crx_active && !crx_data_available && !rsp_valid_q
                             && !crx_read_q) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    status_d   = STATUS_OK;
                    err_code_d = '0;
                end
            end
            ST_RECOVER: begin
                if (timer_tc) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    status_d   = STATUS_RX_ERROR;
                    err_code_d = err_hold_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Error path discards any read issued in the same cycle
        if (state_d == ST_RECOVER) begin
            crx_read_d = 1'b0;
        end

        busy_d       = (state_d != ST_IDLE);
        crx_enable_d = (state_d == ST_RX_WAIT) || (state_d == ST_RX);
        crx_reset_d  = (state_d == ST_RECOVER);
    end

`ifdef COAX_LINK_CTRL_STATS_EN
    // Saturating outcome counters
    always_comb begin
        timeout_count_d = timeout_count_q;
        error_count_d   = error_count_q;
        if (done_d && (status_d == STATUS_TIMEOUT)) begin
            timeout_count_d = sat_inc(timeout_count_q);
        end
        if (done_d && (status_d == STATUS_RX_ERROR)) begin
            error_count_d = sat_inc(error_count_q);
        end
    end
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ctx_data_q    <= '0;
            ctx_load_q    <= 1'b0;
            seen_active_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_word_q    <= '0;
            crx_read_q    <= 1'b0;
            err_hold_q    <= '0;
            done_q        <= 1'b0;
            status_q      <= STATUS_OK;
            err_code_q    <= '0;
            busy_q        <= 1'b0;
            crx_enable_q  <= 1'b0;
            crx_reset_q   <= 1'b1;
`ifdef COAX_LINK_CTRL_STATS_EN
            timeout_count_q <= '0;
            error_count_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ctx_data_q    <= ctx_data_d;
            ctx_load_q    <= ctx_load_d;
            seen_active_q <= seen_active_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_word_q    <= rsp_word_d;
            crx_read_q    <= crx_read_d;
            err_hold_q    <= err_hold_d;
            done_q        <= done_d;
            status_q      <= status_d;
            err_code_q    <= err_code_d;
            busy_q        <= busy_d;
            crx_enable_q  <= crx_enable_d;
            crx_reset_q   <= crx_reset_d;
`ifdef COAX_LINK_CTRL_STATS_EN
            timeout_count_q <= timeout_count_d;
            error_count_q   <= error_count_d;
`endif
        end
    end

    assign tx_ready   = tx_ready_c;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_word   = rsp_word_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign status     = status_q;
    assign err_code   = err_code_q;
    assign ctx_data   = ctx_data_q;
    assign ctx_load   = ctx_load_q;
    assign crx_read   = crx_read_q;
    assign crx_reset  = crx_reset_q;
    assign crx_enable = crx_enable_q;
`ifdef COAX_LINK_CTRL_STATS_EN
    assign timeout_count = timeout_count_q;
    assign error_count   = error_count_q;
`endif

endmodule

// File: tb/tb_coax_link_ctrl.sv
// Directed testbench for coax_link_ctrl with a small coax_tx activity model
// and scripted coax_rx behaviour. Optional COAX_LINK_CTRL_STATS_EN checks counters.
module tb_coax_link_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [9:0] tx_word = '0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       rsp_valid;
    logic [9:0] rsp_word;
    logic       rsp_ready = 1'b1;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic [9:0] err_code;
    logic [9:0] ctx_data;
    logic       ctx_load;
    logic       ctx_ready = 1'b1;
    logic       ctx_active = 1'b0;
    logic [9:0] crx_data = '0;
    logic       crx_data_available = 1'b0;
    logic       crx_error = 1'b0;
    logic       crx_active = 1'b0;
    logic       crx_read;
    logic       crx_reset;
    logic       crx_enable;
`ifdef COAX_LINK_CTRL_STATS_EN
    logic [15:0] timeout_count;
    logic [15:0] error_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state (written only by the monitor process)
    logic [9:0] load_words [8];
    logic [9:0] rsp_words  [8];
    int load_n = 0;
    int rsp_n = 0;
    int read_n = 0;
    int done_n = 0;
    int overlap_n = 0;
    int tx_cnt = 0;

    coax_link_ctrl dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .tx_valid           (tx_valid),
        .tx_word            (tx_word),
        .tx_last            (tx_last),
        .tx_ready           (tx_ready),
        .rsp_valid          (rsp_valid),
        .rsp_word           (rsp_word),
        .rsp_ready          (rsp_ready),
        .busy               (busy),
        .done               (done),
        .status             (status),
        .err_code           (err_code),
        .ctx_data           (ctx_data),
        .ctx_load           (ctx_load),
        .ctx_ready          (ctx_ready),
        .ctx_active         (ctx_active),
        .crx_data           (crx_data),
        .crx_data_available (crx_data_available),
        .crx_error          (crx_error),
        .crx_active         (crx_active),
        .crx_read           (crx_read),
        .crx_reset          (crx_reset),
        .crx_enable         (crx_enable)
`ifdef COAX_LINK_CTRL_STATS_EN
        ,
        .timeout_count      (timeout_count),
        .error_count        (error_count)
`endif
    );

    always #5 clk = ~clk;

    // Monitors plus coax_tx model: line stays active 5 clocks after each load
    always @(negedge clk) begin
        if (ctx_load) begin
            if (load_n < 8) load_words[load_n] = ctx_data;
            load_n++;
            tx_cnt = 5;
        end else if (tx_cnt != 0) begin
            tx_cnt--;
        end
        ctx_active = (tx_cnt != 0);
        if (crx_read) read_n++;
        if (done) done_n++;
        if (rsp_valid && rsp_ready) begin
            if (rsp_n < 8) rsp_words[rsp_n] = rsp_word;
            rsp_n++;
        end
        if (crx_enable && ctx_active) overlap_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w, input logic last, output bit ok);
        tx_valid = 1'b1;
        tx_word  = w;
        tx_last  = last;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_enable(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (crx_enable) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int budget, output int n, output bit ok);
        ok = 1'b0;
        n = 0;
        while (n < budget) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic deliver(input logic [9:0] w, output bit ok);
        crx_data = w;
        crx_data_available = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (crx_read) begin
                ok = 1'b1;
                break;
            end
        end
        crx_data_available = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({tx_ready, rsp_valid, busy, done, ctx_load, crx_read, crx_enable} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_strobes: got %b expected 0000000",
                     {tx_ready, rsp_valid, busy, done, ctx_load, crx_read, crx_enable});
        end
        n_checks++;
        if ({rsp_word, err_code, ctx_data, status} !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_data: got %h expected 0", {rsp_word, err_code, ctx_data, status});
        end
        n_checks++;
        if (crx_reset !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_crx_reset: got %b expected 1", crx_reset);
        end
`ifdef COAX_LINK_CTRL_STATS_EN
        n_checks++;
        if ({timeout_count, error_count} !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_stats: got %h expected 0", {timeout_count, error_count});
        end
`endif
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({crx_reset, busy, tx_ready} !== 3'b001) begin
            n_errors++;
            $display("FAIL reset_release: got %b expected 001", {crx_reset, busy, tx_ready});
        end
    endtask

    task automatic test_basic();
        bit ok;
        int n;
        int l0 = load_n;
        int r0 = rsp_n;
        int rd0 = read_n;
        int d0 = done_n;
        int ov0 = overlap_n;
        rsp_ready = 1'b1;
        send_word(10'h1A5, 1'b0, ok);
        n_checks++;
        if (busy !== 1'b1 || !ok) begin
            n_errors++;
            $display("FAIL basic_busy: got %b ok %0d expected 1", busy, ok);
        end
        send_word(10'h2C3, 1'b1, ok);
        wait_enable(ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL basic_enable: crx_enable never rose expected 1");
        end
        n_checks++;
        if (load_n - l0 !== 2 || load_words[l0] !== 10'h1A5 || load_words[l0+1] !== 10'h2C3) begin
            n_errors++;
            $display("FAIL basic_ctx_load: got %0d loads %h %h expected 2 loads 1a5 2c3",
                     load_n - l0, load_words[l0], load_words[l0+1]);
        end
        n_checks++;
        if (overlap_n - ov0 !== 0) begin
            n_errors++;
            $display("FAIL basic_enable_during_tx: got %0d cycles expected 0", overlap_n - ov0);
        end
        crx_active = 1'b1;
        deliver(10'h133, ok);
        deliver(10'h0F0, ok);
        tick();
        crx_active = 1'b0;
        wait_done(50, n, ok);
        n_checks++;
        if (!ok || status !== 2'b00 || err_code !== 10'h0) begin
            n_errors++;
            $display("FAIL basic_done: done %0d status %b err %h expected 1 00 000", ok, status, err_code);
        end
        n_checks++;
        if (rsp_n - r0 !== 2 || rsp_words[r0] !== 10'h133 || rsp_words[r0+1] !== 10'h0F0) begin
            n_errors++;
            $display("FAIL basic_rsp: got %0d words %h %h expected 2 words 133 0f0",
                     rsp_n - r0, rsp_words[r0], rsp_words[r0+1]);
        end
        n_checks++;
        if (read_n - rd0 !== 2) begin
            n_errors++;
            $display("FAIL basic_reads: got %0d expected 2", read_n - rd0);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_n - d0 !== 1 || status !== 2'b00) begin
            n_errors++;
            $display("FAIL basic_idle: done %b busy %b pulses %0d status %b expected 0 0 1 00",
                     done, busy, done_n - d0, status);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        int rd0 = read_n;
        send_word(10'h077, 1'b1, ok);
        wait_enable(ok);
        wait_done(600, n, ok);
        n_checks++;
        if (!ok || n !== 512) begin
            n_errors++;
            $display("FAIL timeout_latency: done %0d after %0d clocks expected 1 after 512", ok, n);
        end
        n_checks++;
        if (status !== 2'b01 || err_code !== 10'h0) begin
            n_errors++;
            $display("FAIL timeout_status: got %b %h expected 01 000", status, err_code);
        end
        n_checks++;
        if (read_n - rd0 !== 0) begin
            n_errors++;
            $display("FAIL timeout_reads: got %0d expected 0", read_n - rd0);
        end
        tick();
        n_checks++;
        if (status !== 2'b01) begin
            n_errors++;
            $display("FAIL timeout_status_hold: got %b expected 01", status);
        end
    endtask

    task automatic test_rx_error();
        bit ok;
        int n = 0;
        int rst_cnt = 0;
        rsp_ready = 1'b0;
        send_word(10'h155, 1'b1, ok);
        wait_enable(ok);
        crx_active = 1'b1;
        deliver(10'h055, ok);
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_word !== 10'h055) begin
            n_errors++;
            $display("FAIL rxerr_buffered: got %b %h expected 1 055", rsp_valid, rsp_word);
        end
        crx_data = 10'h002;
        crx_error = 1'b1;
        ok = 1'b0;
        while (n < 20) begin
            tick();
            n++;
            crx_error = 1'b0;
            crx_active = 1'b0;
            if (crx_reset) rst_cnt++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok || rst_cnt !== 2 || n !== 3) begin
            n_errors++;
            $display("FAIL rxerr_recover: done %0d crx_reset clocks %0d done at %0d expected 1 2 3",
                     ok, rst_cnt, n);
        end
        n_checks++;
        if (status !== 2'b10 || err_code !== 10'h002 || rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rxerr_status: got %b %h %b expected 10 002 0", status, err_code, rsp_valid);
        end
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        int rd0;
        rsp_ready = 1'b0;
        send_word(10'h2AA, 1'b1, ok);
        wait_enable(ok);
        crx_active = 1'b1;
        rd0 = read_n;
        deliver(10'h111, ok);
        crx_data = 10'h222;
        crx_data_available = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (read_n - rd0 !== 1 || rsp_valid !== 1'b1 || rsp_word !== 10'h111) begin
            n_errors++;
            $display("FAIL bp_single_read: got %0d reads %b %h expected 1 reads 1 111",
                     read_n - rd0, rsp_valid, rsp_word);
        end
        crx_data_available = 1'b0;
        crx_data = 10'h008;
        crx_error = 1'b1;
        tick();
        crx_error = 1'b0;
        crx_active = 1'b0;
        wait_done(20, n, ok);
        n_checks++;
        if (!ok || status !== 2'b10 || err_code !== 10'h008) begin
            n_errors++;
            $display("FAIL bp_overflow: done %0d status %b err %h expected 1 10 008", ok, status, err_code);
        end
`ifdef COAX_LINK_CTRL_STATS_EN
        n_checks++;
        if (timeout_count !== 16'd1 || error_count !== 16'd2) begin
            n_errors++;
            $display("FAIL bp_stats: got %0d %0d expected 1 2", timeout_count, error_count);
        end
`endif
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_rx();
        bit ok;
        int d0;
        send_word(10'h3C1, 1'b1, ok);
        wait_enable(ok);
        crx_active = 1'b1;
        deliver(10'h3AB, ok);
        tick();
        n_checks++;
        if (busy !== 1'b1 || crx_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_in_rx: got %b %b expected 1 1", busy, crx_enable);
        end
        d0 = done_n;
        reset_n = 1'b0;
        tick();
        n_checks++;
        if ({busy, crx_enable, crx_reset, rsp_valid, status} !== 6'b001000) begin
            n_errors++;
            $display("FAIL midrst_abort: got %b expected 001000",
                     {busy, crx_enable, crx_reset, rsp_valid, status});
        end
        reset_n = 1'b1;
        crx_active = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (done_n - d0 !== 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_no_done: got %0d pulses busy %b expected 0 0", done_n - d0, busy);
        end
`ifdef COAX_LINK_CTRL_STATS_EN
        n_checks++;
        if ({timeout_count, error_count} !== 32'h0) begin
            n_errors++;
            $display("FAIL midrst_stats: got %h expected 0", {timeout_count, error_count});
        end
`endif
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        tick();
        test_timeout();
        tick();
        test_rx_error();
        tick();
        test_backpressure();
        tick();
        test_reset_mid_rx();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
